// File: rtl/axi_w_mem_writer.sv
// AXI write-data reader for the axi_to_mem path: walks one AW burst at a time,
// turns each W beat into a memory write, and returns one B response per burst.
module axi_w_mem_writer #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    // AW descriptor
    input  logic                     aw_valid_i,
    output logic                     aw_ready_o,
    input  logic [IdWidth-1:0]       aw_id_i,
    input  logic [AddrWidth-1:0]     aw_addr_i,
    input  logic [7:0]               aw_len_i,
    input  logic [2:0]               aw_size_i,
    input  logic [1:0]               aw_burst_i,
    // W FIFO head
    input  logic                     w_valid_i,
    output logic                     w_ready_o,
    input  logic [DataWidth-1:0]     w_data_i,
    input  logic [DataWidth/8-1:0]   w_strb_i,
    input  logic                     w_last_i,
    input  logic [UserWidth-1:0]     w_user_i,
    // memory write port
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic [AddrWidth-1:0]     mem_addr_o,
    output logic [DataWidth-1:0]     mem_wdata_o,
    output logic [DataWidth/8-1:0]   mem_strb_o,
    output logic [UserWidth-1:0]     mem_user_o,
    output logic                     mem_we_o,
    // B response
    output logic                     b_valid_o,
    input  logic                     b_ready_i,
    output logic [IdWidth-1:0]       b_id_o,
    output logic [1:0]               b_resp_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned MaxSize   = $clog2(StrbWidth);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBurst = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    logic [1:0]           state_q, state_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic                 err_q, err_d;
    logic                 drop_q, drop_d;

    logic                 aw_bad;
    logic                 wrap_len_ok;
    logic                 beat_fire;
    logic                 beat_is_last;
    logic [AddrWidth-1:0] step;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] addr_next;

    // Descriptor checks: reserved burst type or a beat wider than the bus drops the burst.
    assign aw_bad      = (aw_burst_i == BurstRsvd) || (aw_size_i > 3'(MaxSize));
    assign wrap_len_ok = aw_len_i inside {8'd1, 8'd3, 8'd7, 8'd15};

    // Next beat address for the latched burst; all sums wrap modulo 2^AddrWidth.
    assign step      = AddrWidth'(1) << size_q;
    assign wrap_mask = ((AddrWidth'(len_q) + AddrWidth'(1)) << size_q) - AddrWidth'(1);

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            BurstFixed: addr_next = addr_q;
            BurstWrap:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default:    addr_next = (addr_q & ~(step - AddrWidth'(1))) + step;
        endcase
    end

    // Handshake decode; dropped bursts pop W unconditionally and never touch memory.
    assign aw_ready_o   = (state_q == StIdle);
    assign mem_req_o    = (state_q == StBurst) && !drop_q && w_valid_i;
    assign w_ready_o    = (state_q == StBurst) && (drop_q || (mem_gnt_i && w_valid_i));
    assign beat_fire    = w_valid_i && w_ready_o;
    assign beat_is_last = (cnt_q == len_q);

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = w_data_i;
    assign mem_strb_o  = w_strb_i;
    assign mem_user_o  = w_user_i;
    assign mem_we_o    = mem_req_o;

    assign b_valid_o = (state_q == StResp);
    assign b_id_o    = id_q;
    assign b_resp_o  = ((state_q == StResp) && err_q) ? RespSlvErr : RespOkay;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = err_q;
        drop_d  = drop_q;

        case (state_q)
            StIdle: begin
                if (aw_valid_i) begin
                    id_d    = aw_id_i;
                    addr_d  = aw_addr_i;
                    len_d   = aw_len_i;
                    size_d  = aw_size_i;
                    cnt_d   = 8'd0;
                    drop_d  = aw_bad;
                    // A WRAP with an illegal length still writes, but walks as INCR.
                    if (aw_burst_i == BurstWrap && !wrap_len_ok) begin
                        burst_d = BurstIncr;
                        err_d   = 1'b1;
                    end else begin
                        burst_d = aw_burst_i;
                        err_d   = aw_bad;
                    end
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (beat_fire) begin
                    if (w_last_i != beat_is_last) begin
                        err_d = 1'b1;
                    end
                    if (beat_is_last) begin
                        state_d = StResp;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = addr_next;
                    end
                end
            end
            StResp: begin
                if (b_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and descriptor registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_axi_w_mem_writer.sv
// Randomised scoreboard bench for axi_w_mem_writer: a queue-based W FIFO feeds the
// DUT, expected writes/responses come from a burst-level address model.
module tb_axi_w_mem_writer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 1;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned MAXSZ = $clog2(SW);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
    } wr_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_t;

    logic          clk_i;
    logic          rst_ni;
    logic          aw_valid_i, aw_ready_o;
    logic [IW-1:0] aw_id_i;
    logic [AW-1:0] aw_addr_i;
    logic [7:0]    aw_len_i;
    logic [2:0]    aw_size_i;
    logic [1:0]    aw_burst_i;
    logic          w_valid_i, w_ready_o;
    logic [DW-1:0] w_data_i;
    logic [SW-1:0] w_strb_i;
    logic          w_last_i;
    logic [UW-1:0] w_user_i;
    logic          mem_req_o, mem_gnt_i, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [SW-1:0] mem_strb_o;
    logic [UW-1:0] mem_user_o;
    logic          b_valid_o, b_ready_i;
    logic [IW-1:0] b_id_o;
    logic [1:0]    b_resp_o;

    axi_w_mem_writer #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .UserWidth(UW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
        .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
        .aw_burst_i(aw_burst_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .w_strb_i(w_strb_i), .w_last_i(w_last_i), .w_user_i(w_user_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_user_o(mem_user_o),
        .mem_we_o(mem_we_o),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    beat_t wq[$];
    wr_t   exp_mem[$];
    b_t    exp_b[$];

    int n_cmp = 0;
    int n_err = 0;
    int tmo_count = 0;
    int tmo_seen = 0;

    int unsigned wv_pct = 100;
    int unsigned gnt_pct = 100;
    int unsigned b_pct = 100;

    // flags sampled by the monitor, consumed after the following rising edge
    bit aw_fired, w_fired;

    // monitor-private tracking
    int            cur_len, beat_n;
    bit            b_due, b_pend, b_fire_prev, stall_pend;
    logic [IW-1:0] hold_id;
    logic [1:0]    hold_resp;
    logic [AW-1:0] stall_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte address of beat i, straight from the AXI burst rules.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst,
                                                input int i);
        longint unsigned step, start, nb, base, idx;
        step  = 64'd1 << size;
        start = longint'(a);
        idx   = longint'(i);
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            nb   = (longint'(len) + 64'd1) * step;
            base = start - (start % nb);
            return AW'(base + ((start - base + idx * step) % nb));
        end
        if (i == 0) return a;
        return AW'(start - (start % step) + idx * step);
    endfunction

    // W FIFO emulation and random grant/response back-pressure
    always @(posedge clk_i) begin
        #1;
        if (w_fired && wq.size() > 0) void'(wq.pop_front());
        w_valid_i = (wq.size() > 0) && ($urandom_range(99) < wv_pct);
        if (wq.size() > 0) {w_data_i, w_strb_i, w_last_i, w_user_i} = wq[0];
        mem_gnt_i = $urandom_range(99) < gnt_pct;
        b_ready_i = $urandom_range(99) < b_pct;
    end

    // Monitor / scoreboard
    always @(negedge clk_i) begin
        wr_t e;
        b_t  r;
        aw_fired = 1'b0;
        w_fired  = 1'b0;
        if (!rst_ni) begin
            chk("rst_aw_ready", aw_ready_o, 1);
            chk("rst_w_ready", w_ready_o, 0);
            chk("rst_mem_req", mem_req_o, 0);
            chk("rst_b_valid", b_valid_o, 0);
            chk("rst_b_resp", b_resp_o, 0);
            chk("rst_b_id", b_id_o, 0);
            chk("rst_mem_addr", mem_addr_o, 0);
            b_due = 0; b_pend = 0; b_fire_prev = 0; stall_pend = 0; beat_n = 0;
        end else begin
            aw_fired = aw_valid_i && aw_ready_o;
            if (aw_fired) begin
                cur_len = int'(aw_len_i);
                beat_n  = 0;
            end
            if (b_due) chk("b_after_last_beat", b_valid_o, 1);
            b_due = 0;
            if (b_fire_prev) chk("aw_ready_after_b", aw_ready_o, 1);
            if (b_pend) chk("b_hold", {b_valid_o, b_id_o, b_resp_o}, {1'b1, hold_id, hold_resp});
            if (b_valid_o || aw_ready_o) chk("no_w_outside_burst", {w_ready_o, mem_req_o}, 0);
            if (b_valid_o) chk("aw_ready_in_resp", aw_ready_o, 0);
            if (stall_pend && mem_req_o) chk("stall_addr_hold", mem_addr_o, stall_addr);
            if (mem_req_o) begin
                chk("mem_we", mem_we_o, 1);
                if (mem_gnt_i) begin
                    if (exp_mem.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: addr 0x%0h, no write expected at %0t",
                                 mem_addr_o, $time);
                    end else begin
                        e = exp_mem.pop_front();
                        chk("mem_addr", mem_addr_o, e.addr);
                        chk("mem_wdata", mem_wdata_o, e.data);
                        chk("mem_strb", mem_strb_o, e.strb);
                        chk("mem_user", mem_user_o, e.user);
                    end
                end
            end
            stall_pend = mem_req_o && !mem_gnt_i;
            stall_addr = mem_addr_o;
            w_fired = w_valid_i && w_ready_o;
            if (w_fired) begin
                if (beat_n == cur_len) b_due = 1;
                else beat_n++;
            end
            b_fire_prev = b_valid_o && b_ready_i;
            if (b_fire_prev) begin
                if (exp_b.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_b: id 0x%0h resp %0b at %0t", b_id_o, b_resp_o, $time);
                end else begin
                    r = exp_b.pop_front();
                    chk("b_id", b_id_o, r.id);
                    chk("b_resp", b_resp_o, r.resp);
                end
            end
            b_pend    = b_valid_o && !b_ready_i;
            hold_id   = b_id_o;
            hold_resp = b_resp_o;
        end
        chk("timeout", tmo_count, tmo_seen);
        tmo_seen = tmo_count;
    end

    // Queue the beats, present AW, and push the expected writes and response once accepted.
    task automatic send_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int bad_last);
        beat_t b;
        wr_t   w;
        b_t    r;
        wr_t   wl[$];
        bit    mism, drop, wrap_bad;
        int    n;
        mism     = 0;
        drop     = (burst == 2'b11) || (size > 3'(MAXSZ));
        wrap_bad = (burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
        for (int i = 0; i <= int'(len); i++) begin
            b.data = {$urandom, $urandom};
            b.strb = SW'($urandom);
            b.user = UW'($urandom);
            b.last = (bad_last < 0) ? (i == int'(len)) : (i == bad_last);
            if (b.last != (i == int'(len))) mism = 1;
            wq.push_back(b);
            if (!drop) begin
                w.addr = beat_addr(addr, len, size, wrap_bad ? 2'b01 : burst, i);
                w.data = b.data;
                w.strb = b.strb;
                w.user = b.user;
                wl.push_back(w);
            end
        end
        r.id   = id;
        r.resp = (drop || wrap_bad || mism) ? 2'b10 : 2'b00;
        @(posedge clk_i); #2;
        aw_valid_i = 1'b1;
        aw_id_i    = id;
        aw_addr_i  = addr;
        aw_len_i   = len;
        aw_size_i  = size;
        aw_burst_i = burst;
        n = 0;
        do begin
            @(posedge clk_i); #2;
            n++;
        end while (!aw_fired && n < 2000);
        if (!aw_fired) tmo_count++;
        aw_valid_i = 1'b0;
        foreach (wl[k]) exp_mem.push_back(wl[k]);
        exp_b.push_back(r);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((wq.size() != 0 || exp_mem.size() != 0 || exp_b.size() != 0) && n < 4000) begin
            @(posedge clk_i); #2;
            n++;
        end
        if (n >= 4000) tmo_count++;
    endtask

    initial begin
        int n;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [AW-1:0] addr;
        int bad;
        rst_ni = 1'b0;
        aw_valid_i = 0; aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0;
        aw_size_i = '0; aw_burst_i = '0;
        w_valid_i = 0; w_data_i = '0; w_strb_i = '0; w_last_i = 0; w_user_i = '0;
        mem_gnt_i = 1; b_ready_i = 1;
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;

        send_burst(4'h5, 32'h1000, 8'd3, 3'd3, 2'b01, -1);
        wait_idle();
        send_burst(4'h2, 32'h1003, 8'd1, 3'd3, 2'b01, -1);
        wait_idle();
        send_burst(4'h7, 32'h000C, 8'd3, 3'd2, 2'b10, -1);
        wait_idle();
        send_burst(4'h9, 32'h2000, 8'd3, 3'd3, 2'b01, 1);
        wait_idle();
        send_burst(4'hA, 32'h3000, 8'd1, 3'd3, 2'b11, -1);
        wait_idle();
        send_burst(4'h3, 32'h5000, 8'd7, 3'd2, 2'b01, -1);
        wait_idle();

        // response held under back-pressure while the next burst's beats wait
        b_pct = 0;
        send_burst(4'hC, 32'h4000, 8'd3, 3'd3, 2'b01, -1);
        n = 0;
        while (!b_valid_o && n < 200) begin @(posedge clk_i); #2; n++; end
        if (!b_valid_o) tmo_count++;
        fork
            send_burst(4'hD, 32'h4100, 8'd1, 3'd3, 2'b01, -1);
        join_none
        repeat (5) @(posedge clk_i);
        b_pct = 100;
        wait fork;
        wait_idle();

        // grant stalls
        gnt_pct = 40;
        send_burst(4'h4, 32'h6000, 8'd7, 3'd3, 2'b01, -1);
        wait_idle();
        gnt_pct = 100;

        // reset in the middle of a burst
        send_burst(4'h6, 32'h7000, 8'd3, 3'd3, 2'b01, -1);
        n = 0;
        while (exp_mem.size() > 3 && n < 200) begin @(posedge clk_i); #2; n++; end
        if (exp_mem.size() > 3) tmo_count++;
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        wq.delete();
        exp_mem.delete();
        exp_b.delete();
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        send_burst(4'h1, 32'h0040, 8'd2, 3'd3, 2'b00, -1);
        wait_idle();

        // randomised bursts
        for (int t = 0; t < 60; t++) begin
            wv_pct  = ($urandom_range(1) == 0) ? 100 : 70;
            gnt_pct = ($urandom_range(1) == 0) ? 100 : 60;
            b_pct   = ($urandom_range(1) == 0) ? 100 : 50;
            burst = 2'($urandom_range(3));
            size  = ($urandom_range(9) == 0) ? 3'(4 + $urandom_range(3)) : 3'($urandom_range(3));
            len   = 8'($urandom_range(20));
            if (burst == 2'b10 && $urandom_range(3) != 0) len = 8'((2 << $urandom_range(3)) - 1);
            addr  = ($urandom_range(7) == 0) ? (32'hFFFF_FFC0 | AW'($urandom_range(63))) : AW'($urandom);
            bad   = ($urandom_range(7) == 0) ? int'($urandom_range(int'(len) + 1)) : -1;
            send_burst(IW'($urandom), addr, len, size, burst, bad);
            if ($urandom_range(1) == 0) wait_idle();
        end
        wait_idle();
        repeat (3) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_w_mem_writer.md
Name: axi_w_mem_writer

Overview:
- Reader side of the AXI write-data buffer in the axi_to_mem path.
- Accepts one AW burst descriptor at a time and pops W beats (data/strb/last/user) from the upstream W FIFO.
- Converts each beat into a single-port memory write request with computed byte address.
- Issues one B response per burst, with SLVERR on protocol or descriptor errors.

Parameters:
AddrWidth, 32, byte-address width of AW and memory port
DataWidth, 64, W/memory data width in bits (power of 2, >=8)
IdWidth, 4, AXI ID width
UserWidth, 1, W user width (forwarded to memory)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
aw_valid_i  in  1  AW descriptor valid
aw_ready_o  out  1  AW accept
aw_id_i  in  IdWidth  burst ID
aw_addr_i  in  AddrWidth  start byte address
aw_len_i  in  8  beats minus one
aw_size_i  in  3  log2 bytes per beat
aw_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
w_valid_i  in  1  W beat available (FIFO not empty)
w_ready_o  out  1  W pop
w_data_i  in  DataWidth  beat data
w_strb_i  in  DataWidth/8  byte strobes
w_last_i  in  1  last-beat marker
w_user_i  in  UserWidth  beat user bits
mem_req_o  out  1  memory write request
mem_gnt_i  in  1  memory grant
mem_addr_o  out  AddrWidth  write byte address
mem_wdata_o  out  DataWidth  = w_data_i
mem_strb_o  out  DataWidth/8  = w_strb_i
mem_user_o  out  UserWidth  = w_user_i
mem_we_o  out  1  constant 1 while mem_req_o
b_valid_o  out  1  write response valid
b_ready_i  in  1  response accept
b_id_o  out  IdWidth  latched aw_id_i
b_resp_o  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Reset: rst_ni is asynchronous and active-low; clock is clk_i.
  - State goes to IDLE; beat counter, latched descriptor and error flag clear.
  - Outputs during and after reset: aw_ready_o=1, w_ready_o=0, mem_req_o=0, b_valid_o=0, b_resp_o=00, b_id_o=0, mem_addr_o=0.
- FSM states: IDLE, BURST, RESP.
- IDLE:
  - aw_ready_o=1.
  - On aw_valid_i&aw_ready_o: latch id, addr, len, size, burst; cnt=0.
  - err is set if aw_burst_i==11 or aw_size_i > log2(DataWidth/8), else cleared.
  - Next state is BURST.
- BURST: aw_ready_o=0.
  - Legal burst: mem_req_o=w_valid_i and w_ready_o=mem_gnt_i&w_valid_i. mem_req_o must not depend on mem_gnt_i.
  - Illegal burst (err set at AW): mem_req_o=0 and w_ready_o=1. Beats are drained and dropped.
  - A beat is accepted on w_valid_i&w_ready_o. Throughput is 1 beat/cycle with no bubbles.
  - On acceptance, if cnt==len: go to RESP. Otherwise cnt++ and advance the address.
  - Burst length is set by aw_len_i only; w_last_i never terminates a burst.
  - w_last_i mismatch sets err (sticky): last=1 with cnt!=len, or last=0 with cnt==len.
- Address arithmetic (step = 1<<size):
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(step-1)) + step. The first beat uses the unaligned start address; later beats are aligned.
  - WRAP: mask = ((len+1)<<size)-1; next = (addr & ~mask) | ((addr+step) & mask). Only len in {1,3,7,15} is legal; any other len sets err and the burst is handled as INCR.
  - Addition wraps modulo 2^AddrWidth.
- RESP:
  - b_valid_o=1, b_resp_o = err ? 10 : 00, b_id_o = latched id.
  - Outputs are held stable until b_ready_i.
  - On handshake go to IDLE. There is no AW acceptance in the same cycle (minimum 1 idle cycle).
  - b_valid_o rises the cycle after the last beat is accepted.
- Stalls:
  - While mem_gnt_i=0, mem_addr_o and cnt hold. Data pass-through is stable because the FIFO head is not popped.
  - w_valid_i=0 in BURST: mem_req_o=0 and state holds.
- Reset mid-burst or mid-RESP returns to IDLE immediately. Partial burst state is discarded and no B is issued.
- W beats arriving in IDLE or RESP are not popped (w_ready_o=0).

Test Plan:
- INCR len=3 size=3 addr=0x1000, gnt=1, last on beat 4 -> mem_addr 0x1000,0x1008,0x1010,0x1018 on 4 consecutive cycles; next cycle b_valid=1, b_resp=00, b_id=AW id.
- INCR size=3 addr=0x1003 len=1 -> mem_addr 0x1003 then 0x1008. WRAP len=3 size=2 addr=0x0C -> 0x0C,0x00,0x04,0x08.
- Beat 2 of a len=3 INCR with gnt=0 for 3 cycles -> w_ready_o=0, mem_req_o=1, mem_addr_o held; 4 beats total written, order preserved.
- len=3 with w_last=1 on beat 2 -> 4 beats still written, b_resp=10. Separately, burst=11 with len=1 -> mem_req_o never 1, 2 beats popped, b_resp=10.
- b_ready_i low 5 cycles in RESP -> b_valid/b_id/b_resp held, aw_ready_o=0, no W popped; after handshake, aw_ready_o=1 the following cycle.
- rst_ni pulsed after beat 1 of len=3 -> b_valid_o=0, aw_ready_o=1; a subsequent FIXED len=2 addr=0x40 burst writes 0x40 x3, b_resp=00.
